s2p_rx: RTL and testbench

- Serial-to-parallel receiver; the receiving end of the board's serial shift link (sclk / sdata / sen framing, MSB first).
- Oversamples an externally clocked serial stream on the system clock and reassembles DATA_BITS-bit words.
- Presents each word on a valid/ready parallel port.
- Flags framing errors and overruns.
- Used to read back serial peripherals and to loop back our own serial transmitters for self-test.

---
 rtl/s2p_pkg.sv | 13 +
 rtl/s2p_rx_sync_edge.sv | 31 +++
 rtl/s2p_rx.sv | 104 ++++++++++
 tb/tb_s2p_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: state encoding and width helper shared by the serial receiver
package s2p_pkg;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RECV = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/s2p_rx_sync_edge.sv
// sync_edge: multi-flop synchronizer with optional rising-edge detect
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sr <= '0;
        else sr <= {sr[SYNC_STAGES-2:0], d};

    assign q = sr[SYNC_STAGES-1];

    generate
        if (EDGE) begin : g_edge
            logic q_d;
            always_ff @(posedge clk or negedge rstn)
                if (!rstn) q_d <= 1'b0;
                else q_d <= q;
            assign rise = q & ~q_d;
        end else begin : g_lvl
            assign rise = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/s2p_rx.sv
// s2p_rx: oversampling serial-to-parallel receiver (MSB first) with
// valid/ready output, framing-error and overrun pulses
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int DATA_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sclk,
    input  logic                 sin,
    input  logic                 sen,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = clog2(DATA_BITS + 1);

    logic sclk_lvl_unused, sin_rise_unused, sen_rise_unused;
    logic rise, sin_s, sen_s;
    logic [1:0] state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt, word;
    logic [CW-1:0] cnt, cnt_nxt;
    logic done, ferr_nxt;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sclk (
        .clk(clk), .rstn(rstn), .d(sclk), .q(sclk_lvl_unused), .rise(rise)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sin (
        .clk(clk), .rstn(rstn), .d(sin), .q(sin_s), .rise(sin_rise_unused)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sen (
        .clk(clk), .rstn(rstn), .d(sen), .q(sen_s), .rise(sen_rise_unused)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end

    // the final bit beats a simultaneous sen drop; any earlier bit loses to it
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done      = 1'b0;
        ferr_nxt  = 1'b0;
        word      = {shreg[DATA_BITS-2:0], sin_s};
        case (state)
            IDLE: begin
                if (sen_s) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
                end
            end
            RECV: begin
                if (rise && cnt == CW'(DATA_BITS - 1)) begin
                    state_nxt = DONE;
                    shreg_nxt = word;
                    cnt_nxt   = CW'(DATA_BITS);
                    done      = 1'b1;
                end else if (!sen_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ferr_nxt  = 1'b1;
                end else if (rise) begin
                    shreg_nxt = word;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            DONE: state_nxt = sen_s ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= ferr_nxt;
            overrun   <= done && dout_valid && !dout_ready;
            if (done && (!dout_valid || dout_ready)) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: directed and random frames against a frame-level receiver model
module tb_s2p_rx;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic rstn, sclk, sin, sen, dout_ready;
    logic [DB-1:0] dout;
    logic dout_valid, frame_err, overrun, busy;

    int total = 0, bad = 0;
    int fe_seen = 0, ov_seen = 0, fe0 = 0, ov0 = 0;
    bit bits[$];
    logic [DB-1:0] m_dout = '0;
    bit m_valid = 1'b0, ready_at_done = 1'b0;

    always #5 clk = ~clk;

    s2p_rx #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .sclk(sclk), .sin(sin), .sen(sen),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    // counts high cycles, so a stretched pulse shows up as more than one
    always @(negedge clk) begin
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        sen = 1'b1;
        fe0 = fe_seen;
        ov0 = ov_seen;
        ready_at_done = 1'b0;
        tick(4);
    endtask

    task automatic shift_bit(input bit b, input bit rdy);
        sin = b;
        tick(4);
        sclk = 1'b1;
        bits.push_back(b);
        if (rdy) begin
            tick(2);
            dout_ready = 1'b1;
            tick(1);
            dout_ready = 1'b0;
            ready_at_done = 1'b1;
            tick(1);
        end else tick(4);
        sclk = 1'b0;
    endtask

    task automatic end_frame(input string nm);
        int n, exp_fe, exp_ov;
        logic [DB-1:0] w;
        tick(2);
        sen = 1'b0;
        tick(6);
        n = bits.size();
        exp_fe = (n < DB) ? 1 : 0;
        exp_ov = 0;
        w = '0;
        if (exp_fe == 0) begin
            for (int i = 0; i < DB; i++) w = {w[DB-2:0], bits[i]};
            if (m_valid && !ready_at_done) exp_ov = 1;
            else begin
                m_dout = w;
                m_valid = 1'b1;
            end
        end
        bits.delete();
        total++;
        if (fe_seen - fe0 !== exp_fe) begin
            bad++;
            $display("FAIL %s frame_err pulses got=%0d want=%0d", nm, fe_seen - fe0, exp_fe);
        end
        total++;
        if (ov_seen - ov0 !== exp_ov) begin
            bad++;
            $display("FAIL %s overrun pulses got=%0d want=%0d", nm, ov_seen - ov0, exp_ov);
        end
        total++;
        if (dout_valid !== m_valid) begin
            bad++;
            $display("FAIL %s dout_valid got=%b want=%b", nm, dout_valid, m_valid);
        end
        total++;
        if (dout !== m_dout) begin
            bad++;
            $display("FAIL %s dout got=%h want=%h", nm, dout, m_dout);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy after sen low got=%b want=0", nm, busy);
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, input bit rdy, input string nm);
        start_frame();
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i], rdy && (n - 1 - i) == DB - 1);
        end_frame(nm);
    endtask

    task automatic accept();
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; sclk = 1'b0; sin = 1'b0; sen = 1'b0; dout_ready = 1'b0;
        tick(3);
        total++;
        if ({dout, dout_valid} !== '0) begin
            bad++;
            $display("FAIL reset dout/valid got=%h/%b want=0/0", dout, dout_valid);
        end
        total++;
        if ({frame_err, overrun, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset flags got=%b want=000", {frame_err, overrun, busy});
        end
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_nominal();
        logic [15:0] w;
        w = 16'hA5C3;
        start_frame();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL nominal busy in frame got=%b want=1", busy);
        end
        for (int i = 15; i > 0; i--) shift_bit(w[i], 1'b0);
        sin = w[0];
        tick(4);
        sclk = 1'b1;
        bits.push_back(w[0]);
        tick(4);
        total++;
        if (dout_valid !== 1'b1 || dout !== 16'hA5C3) begin
            bad++;
            $display("FAIL nominal latency valid/dout got=%b/%h want=1/a5c3", dout_valid, dout);
        end
        sclk = 1'b0;
        end_frame("nominal");
    endtask

    task automatic test_handshake();
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (dout_valid !== 1'b1 || dout !== 16'hA5C3) ok = 1'b0;
            tick(1);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold valid/dout got=%b/%h want=1/a5c3", dout_valid, dout);
        end
        accept();
        total++;
        if (dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL accept dout_valid got=%b want=0", dout_valid);
        end
        total++;
        if (dout !== 16'hA5C3) begin
            bad++;
            $display("FAIL accept dout retained got=%h want=a5c3", dout);
        end
    endtask

    task automatic test_overrun();
        send_frame(32'h1234, 16, 1'b0, "ovr_first");
        send_frame(32'hFFFF, 16, 1'b0, "ovr_drop");
        accept();
        send_frame(32'h1234, 16, 1'b0, "ovr_first2");
        send_frame(32'hFFFF, 16, 1'b1, "ovr_ready_at_done");
        accept();
    endtask

    task automatic test_short();
        send_frame(32'h1AB, 9, 1'b0, "short");
        send_frame(32'h00FF, 16, 1'b0, "after_short");
        accept();
    endtask

    task automatic test_extra();
        send_frame(32'hBEEFF, 20, 1'b0, "extra_clocks");
    endtask

    task automatic test_reset_mid();
        start_frame();
        for (int i = 0; i < 5; i++) shift_bit(i[0], 1'b0);
        rstn = 1'b0;
        #1;
        total++;
        if ({dout, dout_valid, busy, frame_err, overrun} !== '0) begin
            bad++;
            $display("FAIL async_reset outputs got=%h/%b/%b/%b/%b want=0", dout, dout_valid, busy, frame_err, overrun);
        end
        m_valid = 1'b0;
        m_dout = '0;
        bits.delete();
        tick(3);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) shift_bit(1'b1, 1'b0);
        end_frame("reset_partial");
        send_frame(32'h8001, 16, 1'b0, "after_reset");
        accept();
    endtask

    task automatic test_random();
        int n;
        logic [31:0] v;
        bit rdy;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) accept();
            n = $urandom_range(5, 20);
            v = $urandom;
            rdy = (n >= DB) && ($urandom_range(0, 1) == 1);
            send_frame(v, n, rdy, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_handshake();
        test_overrun();
        test_short();
        test_extra();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
